// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH valid-tagged pipeline registers: per-stage flush, shared stall.
// Define PIPE_PERF_CNT_EN to build the saturating stall/flush cycle counters.
module pipe_stage_chain #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 2,
    parameter logic [31:0] BUBBLE_VAL = 32'h00000013,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     stall,
    input  logic [DEPTH-1:0]         flush,
    output logic [DEPTH-1:0]         stage_valid,
    output logic [DEPTH*DATA_W-1:0]  stage_data,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    if (DEPTH < 1 || DEPTH > 8) begin : g_depth_chk
        $error("pipe_stage_chain: DEPTH must be in 1..8");
    end

    localparam logic [DATA_W-1:0] BUBBLE = DATA_W'(BUBBLE_VAL);

    logic [DEPTH-1:0]             valid_q, valid_d, src_valid;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d, src_data;

    // Stage 0 is fed from the input port, stage i from stage i-1.
    always_comb begin
        src_valid    = '0;
        src_data     = '0;
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_valid[i] = valid_q[i-1];
            src_data[i]  = data_q[i-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush[i]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = BUBBLE;
            end else if (!stall) begin
                valid_d[i] = src_valid[i];
                data_d[i]  = src_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            data_q  <= {DEPTH{BUBBLE}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign stage_valid = valid_q;
    assign stage_data  = data_q;
    assign out_valid   = valid_q[DEPTH-1];
    assign out_data    = data_q[DEPTH-1];

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((|flush) && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: queue-based shift model, random and
// directed stall/flush/reset traffic.
module tb_pipe_stage_chain;

    localparam int D  = 2;
    localparam int W  = 32;
    localparam int CW = 4;
    localparam logic [W-1:0] BUB = 32'h00000013;

    typedef struct {
        bit           v;
        logic [W-1:0] d;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic [W-1:0]    in_data = '0;
    logic            stall = 1'b0;
    logic [D-1:0]    flush = '0;
    logic [D-1:0]    stage_valid;
    logic [D*W-1:0]  stage_data;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [CW-1:0]   stall_cnt;
    logic [CW-1:0]   flush_cnt;

    int checks = 0;
    int errors = 0;

    ent_t         pipe[$];
    logic [W-1:0] sb[$];
    logic [CW-1:0] exp_sc, exp_fc;
    bit           mon_en = 1'b0;
    logic [W-1:0] mon_exp;

    always #5 clk = ~clk;

    pipe_stage_chain #(
        .DATA_W(W), .DEPTH(D), .BUBBLE_VAL(32'h00000013), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .stall(stall), .flush(flush), .stage_valid(stage_valid),
        .stage_data(stage_data), .out_valid(out_valid), .out_data(out_data),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < D; i++) pipe.push_back('{1'b0, BUB});
        sb.delete();
        exp_sc = '0;
        exp_fc = '0;
    endtask

    task automatic check_state();
        logic [D-1:0]   ev;
        logic [D*W-1:0] ed;
        for (int i = 0; i < D; i++) begin
            ev[i]         = pipe[i].v;
            ed[i*W +: W]  = pipe[i].d;
        end
        chk("stage_valid", 64'(stage_valid), 64'(ev));
        chk("stage_data", 64'(stage_data), 64'(ed));
        chk("out_valid", 64'(out_valid), 64'(ev[D-1]));
        chk("stall_cnt", 64'(stall_cnt), 64'(exp_sc));
        chk("flush_cnt", 64'(flush_cnt), 64'(exp_fc));
    endtask

    // Called at a falling edge: check, drive, advance the model past one rising edge.
    task automatic step(bit v, logic [W-1:0] d, bit st, logic [D-1:0] fl);
        ent_t nxt[$];
        check_state();
        in_valid = v;
        in_data  = d;
        stall    = st;
        flush    = fl;
        nxt = pipe;
        if (!st) begin
            nxt.push_front('{v, d});
            void'(nxt.pop_back());
        end
        for (int i = 0; i < D; i++) if (fl[i]) nxt[i] = '{1'b0, BUB};
        pipe = nxt;
        if (pipe[D-1].v) sb.push_back(pipe[D-1].d);
`ifdef PIPE_PERF_CNT_EN
        if (st && exp_sc != '1) exp_sc = exp_sc + 1'b1;
        if ((|fl) && exp_fc != '1) exp_fc = exp_fc + 1'b1;
`endif
        @(negedge clk);
    endtask

    task automatic reset_mid();
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_state();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic rand_steps(int n);
        for (int k = 0; k < n; k++) begin
            step(($urandom_range(3) != 0), $urandom,
                 ($urandom_range(3) == 0),
                 D'(($urandom_range(7) == 0) ? $urandom : 0));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra out_data=%h expected=none", out_data);
            end else begin
                mon_exp = sb.pop_front();
                if (out_data !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_data actual=%h expected=%h", out_data, mon_exp);
                end
            end
        end
    end

    initial begin
        model_reset();
        #12;
        check_state();
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        step(1'b1, 32'hA000_000A, 1'b0, 2'b00);
        step(1'b1, 32'hB000_000B, 1'b0, 2'b00);
        step(1'b1, 32'hC000_000C, 1'b0, 2'b00);
        step(1'b0, 32'h0000_0001, 1'b0, 2'b00);
        step(1'b0, 32'h0000_0002, 1'b0, 2'b00);

        step(1'b1, 32'hA000_000A, 1'b0, 2'b00);
        step(1'b1, 32'hB000_000B, 1'b0, 2'b00);
        repeat (3) step(1'b1, 32'hDEAD_BEEF, 1'b1, 2'b00);
        step(1'b0, 32'h0, 1'b0, 2'b00);
        step(1'b0, 32'h0, 1'b0, 2'b00);

        step(1'b1, 32'hA000_000A, 1'b0, 2'b00);
        step(1'b1, 32'hB000_000B, 1'b0, 2'b00);
        step(1'b1, 32'h1234_5678, 1'b1, 2'b01);
        step(1'b1, 32'hC000_000C, 1'b0, 2'b00);
        step(1'b1, 32'hE000_000E, 1'b0, 2'b00);
        step(1'b1, 32'hF000_000F, 1'b0, 2'b11);
        step(1'b1, 32'h5555_AAAA, 1'b1, 2'b11);

        repeat (20) step(1'($urandom), $urandom, 1'b1, 2'b00);

        step(1'b1, 32'h1111_1111, 1'b0, 2'b00);
        step(1'b1, 32'h2222_2222, 1'b0, 2'b00);
        reset_mid();

        rand_steps(400);
        reset_mid();
        rand_steps(100);
        step(1'b0, 32'h0, 1'b0, 2'b00);

        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
